// File: rtl/register_file_dump.sv
// Two-read/one-write register file with a ready/valid dump streamer that walks every register in order.
// Optional macro REGFILE_BYPASS_EN selects write-first reads on A/B; default build is read-first.
`timescale 1ns/1ps

module register_file_dump #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } dump_state_t;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic [DATA_WIDTH-1:0] r_dump_data;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  r_dump_valid;
    logic                  r_dump_done;
    dump_state_t           r_state;

    dump_state_t           w_next_state;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [DATA_WIDTH-1:0] w_dump_word;
    logic                  w_clear_index;
    logic                  w_capture;
    logic                  w_accept;
    logic                  w_done_set;

    // Register 0 is hard-wired when ZERO_REG is set, so a write there is simply dropped.
    assign w_wr_en = reg_write && !((ZERO_REG != 0) && (write_address == '0));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rd_a = r_regs[read_addr_a];
        w_rd_b = r_regs[read_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (read_addr_a == write_address)) w_rd_a = write_data;
        if (w_wr_en && (read_addr_b == write_address)) w_rd_b = write_data;
`endif
        if ((ZERO_REG != 0) && (read_addr_a == '0)) w_rd_a = '0;
        if ((ZERO_REG != 0) && (read_addr_b == '0)) w_rd_b = '0;
    end

    // The dump path always sees the array as it stood before this edge's write.
    always_comb begin
        w_dump_word = r_regs[r_index];
        if ((ZERO_REG != 0) && (r_index == '0)) w_dump_word = '0;
    end

    // NOTE: the register array is reset too, because reset must leave every entry reading zero.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[write_address] <= write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_data_a <= w_rd_a;
            r_data_b <= w_rd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_clear_index = 1'b0;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    w_clear_index = 1'b1;
                    w_next_state  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_capture    = 1'b1;
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (r_dump_valid && dump_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = (r_index == LAST_INDEX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_done_set   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // dump_done is registered so it lands one edge after DONE is entered.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_index      <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            r_dump_done <= w_done_set;
            if (w_clear_index) r_index <= '0;
            if (w_capture) begin
                r_dump_data  <= w_dump_word;
                r_dump_valid <= 1'b1;
            end
            if (w_accept) begin
                r_dump_valid <= 1'b0;
                if (r_index != LAST_INDEX) r_index <= r_index + 1'b1;
            end
        end
    end

    assign data_a     = r_data_a;
    assign data_b     = r_data_b;
    assign dump_valid = r_dump_valid;
    assign dump_index = r_index;
    assign dump_data  = r_dump_data;
    assign dump_busy  = (r_state != S_IDLE);
    assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_register_file_dump.sv
// Directed bench for register_file_dump: read/write ports, zero register, bypass rule, dump streaming, stall and abort.
`timescale 1ns/1ps

module tb_register_file_dump;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_mem [32];
    logic [31:0] exp_bypass;
    int          nwords;
    int          done_edge;
    int          done_cnt;
    int          busy_cnt;
    logic        stalled;
    logic        found;

    register_file_dump #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_REG  (1)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .read_addr_a  (read_addr_a),
        .read_addr_b  (read_addr_b),
        .write_address(write_address),
        .write_data   (write_data),
        .reg_write    (reg_write),
        .data_a       (data_a),
        .data_b       (data_b),
        .dump_start   (dump_start),
        .dump_ready   (dump_ready),
        .dump_valid   (dump_valid),
        .dump_index   (dump_index),
        .dump_data    (dump_data),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        read_addr_a   = '0;
        read_addr_b   = '0;
        write_address = '0;
        write_data    = '0;
        reg_write     = 1'b0;
        dump_start    = 1'b0;
        dump_ready    = 1'b0;
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h2222_2222;
`else
        exp_bypass = 32'h1111_1111;
`endif
        for (int k = 0; k < 32; k++) exp_mem[k] = (k == 0) ? 32'h0 : 32'(k) * 32'h0101_0101;

        // Reset state
        repeat (2) tick();
        check("rst_data_a", data_a, 32'h0);
        check("rst_data_b", data_b, 32'h0);
        check("rst_dump_valid", 32'(dump_valid), 32'h0);
        check("rst_dump_busy", 32'(dump_busy), 32'h0);
        check("rst_dump_done", 32'(dump_done), 32'h0);
        check("rst_dump_index", 32'(dump_index), 32'h0);
        check("rst_dump_data", dump_data, 32'h0);
        reset_n = 1'b1;

        // Plain write then read with one-edge latency
        reg_write = 1'b1; write_address = 5'd5; write_data = 32'hDEAD_BEEF;
        tick();
        reg_write = 1'b0; read_addr_a = 5'd5;
        tick();
        check("read_a_reg5", data_a, 32'hDEAD_BEEF);

        // Zero register ignores writes, even read in the same cycle
        reg_write = 1'b1; write_address = 5'd0; write_data = 32'h1234_5678; read_addr_b = 5'd0;
        tick();
        check("zero_same_cycle_b", data_b, 32'h0);
        reg_write = 1'b0;
        tick();
        check("zero_read_b", data_b, 32'h0);

        // Same-edge read/write of reg 7; port B reads an unrelated register meanwhile
        reg_write = 1'b1; write_address = 5'd7; write_data = 32'h1111_1111; read_addr_b = 5'd5;
        tick();
        write_data = 32'h2222_2222; read_addr_a = 5'd7;
        tick();
        check("same_edge_rw_a", data_a, exp_bypass);
        check("indep_read_b", data_b, 32'hDEAD_BEEF);
        reg_write = 1'b0;
        tick();
        check("after_write_a", data_a, 32'h2222_2222);

        // Fill reg k with k*0x01010101
        for (int k = 0; k < 32; k++) begin
            reg_write = 1'b1; write_address = 5'(k); write_data = 32'(k) * 32'h0101_0101;
            tick();
        end
        reg_write = 1'b0;

        // Full dump with ready held high
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("busy_after_start", 32'(dump_busy), 32'h1);
        nwords = 0; done_edge = -1; done_cnt = 0;
        for (int e = 1; e <= 80; e++) begin
            tick();
            if (dump_done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (dump_valid) begin
                check("dump1_index", 32'(dump_index), 32'(nwords % 32));
                check("dump1_data", dump_data, exp_mem[nwords % 32]);
                nwords++;
            end
        end
        check("dump1_words", 32'(nwords), 32'd32);
        check("dump1_done_edge", 32'(done_edge), 32'd65);
        check("dump1_done_pulses", 32'(done_cnt), 32'd1);
        check("dump1_idle_busy", 32'(dump_busy), 32'h0);

        // Dump with a three-cycle stall on index 4
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        nwords = 0; done_cnt = 0; stalled = 1'b0;
        for (int e = 1; e <= 120; e++) begin
            tick();
            if (dump_done) done_cnt++;
            if (dump_valid) begin
                if (dump_index == 5'd4 && !stalled) begin
                    stalled    = 1'b1;
                    dump_ready = 1'b0;
                    repeat (3) begin
                        tick();
                        check("stall_valid", 32'(dump_valid), 32'h1);
                        check("stall_index", 32'(dump_index), 32'd4);
                        check("stall_data", dump_data, exp_mem[4]);
                    end
                    dump_ready = 1'b1;
                end
                check("dump2_index", 32'(dump_index), 32'(nwords % 32));
                check("dump2_data", dump_data, exp_mem[nwords % 32]);
                nwords++;
            end
        end
        check("dump2_stalled", 32'(stalled), 32'h1);
        check("dump2_words", 32'(nwords), 32'd32);
        check("dump2_done_pulses", 32'(done_cnt), 32'd1);

        // Reset while index 10 is on offer
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        found = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (dump_valid && dump_index == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_10", 32'(found), 32'h1);
        reset_n = 1'b0;
        tick();
        check("abort_valid", 32'(dump_valid), 32'h0);
        check("abort_busy", 32'(dump_busy), 32'h0);
        check("abort_done", 32'(dump_done), 32'h0);
        check("abort_index", 32'(dump_index), 32'h0);
        check("abort_data", dump_data, 32'h0);
        reset_n = 1'b1;
        done_cnt = 0; busy_cnt = 0;
        repeat (80) begin
            tick();
            if (dump_done) done_cnt++;
            if (dump_busy) busy_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'h0);
        check("abort_no_restart", 32'(busy_cnt), 32'h0);

        // Every register reads zero after the reset
        for (int k = 0; k < 32; k++) begin
            read_addr_a = 5'(k);
            read_addr_b = 5'(31 - k);
            tick();
            check("cleared_a", data_a, 32'h0);
            check("cleared_b", data_b, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_dump.md
REGISTER_FILE_DUMP -- requirements
Module: register_file_dump

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL have one clock and a synchronous, active-low reset, with these ports:
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  synchronous active-low reset.
REQ-007 read_addr_a  in  ADDR_WIDTH  read port A address.
REQ-008 read_addr_b  in  ADDR_WIDTH  read port B address.
REQ-009 write_address  in  ADDR_WIDTH  write port address.
REQ-010 write_data  in  DATA_WIDTH  write port data.
REQ-011 reg_write  in  1  write enable.
REQ-012 data_a  out  DATA_WIDTH  registered read data, port A.
REQ-013 data_b  out  DATA_WIDTH  registered read data, port B.
REQ-014 dump_start  in  1  request to stream all registers out.
REQ-015 dump_ready  in  1  downstream (UART) accepts the current word.
REQ-016 dump_valid  out  1  dump_data/dump_index hold a valid word.
REQ-017 dump_index  out  ADDR_WIDTH  address of the word on dump_data.
REQ-018 dump_data  out  DATA_WIDTH  dumped register value.
REQ-019 dump_busy  out  1  high whenever the dump FSM is not IDLE.
REQ-020 dump_done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-021 Reads on both ports SHALL occur every cycle, independent of reg_write; data_a/data_b update one edge after the address is sampled (latency 1).
REQ-022 A write SHALL update registers[write_address] at the edge where reg_write=1.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 (either port or dump) SHALL return 0.
REQ-024 Same-cycle read and write of one address SHALL follow the rule set by REGFILE_BYPASS_EN (REQ-035/036); a bypass never applies to address 0 when ZERO_REG=1.
REQ-025 Dump FSM states: IDLE, LOAD, SEND, DONE.
REQ-026 IDLE: dump_start=1 -> LOAD with index 0; dump_start SHALL be ignored in every other state.
REQ-027 LOAD: capture registers[index] (array contents before this edge's write) into dump_data; set dump_valid=1 -> SEND.
REQ-028 SEND: while dump_valid=1 and dump_ready=0, dump_data and dump_index SHALL hold stable.
REQ-029 SEND: on dump_valid&&dump_ready, clear dump_valid; if index=DEPTH-1 -> DONE, else index+1 -> LOAD; index SHALL never wrap.
REQ-030 DONE: dump_done=1 for exactly one cycle -> IDLE.
REQ-031 Register writes SHALL proceed normally during a dump; each word reflects contents at its LOAD edge.
REQ-032 With dump_ready tied high, dump_done SHALL go high exactly 2*DEPTH+1 edges after the edge sampling dump_start.

Reset
REQ-033 reset_n=0 at a rising edge SHALL clear all registers, data_a, data_b, dump_data, dump_index to 0; clear dump_valid, dump_busy, dump_done; set the FSM to IDLE; reset takes priority over write and dump_start.
REQ-034 Reset asserted mid-dump SHALL abort it with no dump_done pulse; a new dump_start is needed afterwards.

Configuration
REQ-035 With macro REGFILE_BYPASS_EN defined, a read port whose address equals write_address while reg_write=1 SHALL return write_data (write-first).
REQ-036 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write value (read-first); the dump path is read-first in both builds.

Verification
REQ-037 Reset, then write 0xDEADBEEF to reg 5; read_addr_a=5 next cycle -> data_a=0xDEADBEEF one edge later.
REQ-038 Write 0x12345678 to reg 0 (ZERO_REG=1); read_addr_b=0 -> data_b=0x00000000.
REQ-039 reg 7=0x11111111; same edge write 0x22222222 to reg 7 and read_addr_a=7 -> data_a=0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without.
REQ-040 Reg k=k*0x01010101, dump_start pulse, dump_ready=1 -> 32 words, index 0..31 ascending, data matching, dump_done after edge 65, single pulse.
REQ-041 Dump with dump_ready low for 3 cycles on index 4 -> dump_data/dump_index stable for those cycles, no word dropped or duplicated.
REQ-042 reset_n=0 while dump_index=10 -> next edge dump_valid=0, dump_busy=0, no dump_done, registers all 0.
